// File: rtl/led_arb_pkg.sv
// Shared types, constants and helpers for the LED share arbiter.
package led_arb_pkg;

    // Arbiter states: IDLE shows the heartbeat, OWN shows the owner's
    // pattern, HOLD keeps the last pattern frozen until it has been visible
    // long enough.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Number of LEDs per pattern: {led2, led1}.
    localparam int LED_W = 2;

    // Bits needed to hold the values 0..max_val (ceiling log2, never below 1).
    function automatic int width_for(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module led_tick_gen
    import led_arb_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = width_for(DIV - 1);

    // A divider that does not come out even would drift the timebase.
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 1) begin : g_bad_ratio
        $error("led_tick_gen: CLK_HZ must be a non-zero multiple of TICK_HZ");
    end

    logic [CNT_W-1:0] cnt;

    // Free-running counter 0..DIV-1, wrapping back to zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/led_share_arbiter.sv
// Fixed-priority sharing of the two board LEDs between N_REQ requesters,
// with a minimum visible hold time and an idle complementary heartbeat.
module led_share_arbiter
    import led_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int CLK_HZ         = 100_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int MIN_HOLD_TICKS = 200,
    parameter int HB_HALF_TICKS  = 500
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [LED_W*N_REQ-1:0]   pat,
    output logic [N_REQ-1:0]         gnt,
    output logic                     led1,
    output logic                     led2,
    output logic                     busy
);

    localparam int IDX_W  = width_for(N_REQ - 1);
    localparam int HOLD_W = width_for(MIN_HOLD_TICKS);
    localparam int DIV    = CLK_HZ / TICK_HZ;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("led_share_arbiter: N_REQ must be in 2..8");
    end

    state_t              state_q, state_nxt;
    logic [IDX_W-1:0]    owner_q, win_idx;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [LED_W-1:0]    led_q, led_nxt, owner_pat;
    logic [N_REQ-1:0]    gnt_nxt;
    logic                tick, hb_tick, hb_q;
    logic                any_req, hold_ok, grant_new, busy_nxt;

    // Hold timebase tick.
    led_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Heartbeat timebase: one pulse every HB_HALF_TICKS ticks, phase-aligned
    // with the hold tick because both dividers leave reset together.
    led_tick_gen #(.CLK_HZ(DIV * HB_HALF_TICKS), .TICK_HZ(1)) u_hb_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (hb_tick)
    );

    assign hold_ok = (hold_cnt_q == HOLD_W'(MIN_HOLD_TICKS));

    // Highest requesting index wins; owner pattern lookup.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        win_idx = '0;
        any_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                win_idx = IDX_W'(i);
                any_req = 1'b1;
            end
        end
        owner_pat = pat[LED_W*int'(owner_q) +: LED_W];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic and grant decision.
    always_comb begin
        state_nxt = state_q;
        grant_new = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_nxt = OWN;
                    grant_new = 1'b1;
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    if (!hold_ok) begin
                        state_nxt = HOLD;
                    end else if (any_req) begin
                        grant_new = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (win_idx > owner_q && hold_ok) begin
                    grant_new = 1'b1;
                end
            end
            HOLD: begin
                if (hold_ok) begin
                    if (any_req) begin
                        state_nxt = OWN;
                        grant_new = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        gnt_nxt  = '0;
        led_nxt  = led_q;
        busy_nxt = (state_nxt != IDLE);
        if (state_nxt == OWN) begin
            gnt_nxt = grant_new ? (N_REQ'(1) << win_idx) : gnt;
        end
        unique case (state_q)
            IDLE:    led_nxt = {~hb_q, hb_q};
            OWN:     led_nxt = owner_pat;
            default: led_nxt = led_q;
        endcase
    end

    // Owner index, hold counter and free-running heartbeat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q    <= '0;
            hold_cnt_q <= '0;
            hb_q       <= 1'b0;
        end else begin
            if (grant_new) begin
                owner_q    <= win_idx;
                hold_cnt_q <= '0;
            end else if (tick && !hold_ok) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
            if (hb_tick) begin
                hb_q <= ~hb_q;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt   <= '0;
            led_q <= 2'b10;
            busy  <= 1'b0;
        end else begin
            gnt   <= gnt_nxt;
            led_q <= led_nxt;
            busy  <= busy_nxt;
        end
    end

    assign led1 = led_q[0];
    assign led2 = led_q[1];

endmodule
